// File: rtl/riscv_m_pkg.sv
// Shared RV32M encodings for the multi-cycle multiply/divide units in execute.
// The divider reuses this package for its DIV/DIVU/REM/REMU codes.
package riscv_m_pkg;

  // funct3[1:0] of the M-extension multiply group
  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_unit_seq.sv
// Radix-2 shift-add RV32M multiplier: magnitudes are multiplied unsigned over
// XLEN cycles, then the sign is restored in a single FIX cycle.
module mul_unit_seq
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  mul_state_e          state_q, state_d;
  mul_op_e             op_q, op_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [CW-1:0]       count_q, count_d;
  logic                neg_q, neg_d;
  logic                result_valid_q, result_valid_d;

  logic                rs1_neg, rs2_neg;
  logic [XLEN-1:0]     rs1_abs, rs2_abs;
  logic [2*XLEN-1:0]   product;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !flush) state_d = RUN;
      RUN:     if (flush) state_d = IDLE;
               else if (count_q == CW'(XLEN - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (state_q == RUN) || (state_q == FIX);
    result_valid = result_valid_q;
    result       = result_q;
  end

  // Datapath
  always_comb begin
    rs1_neg = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && rs1[XLEN-1];
    rs2_neg = (op == MUL_OP_MULH) && rs2[XLEN-1];
    // abs of the most negative value wraps to itself, which is the correct magnitude unsigned
    rs1_abs = rs1_neg ? -rs1 : rs1;
    rs2_abs = rs2_neg ? -rs2 : rs2;
    product = neg_q ? -acc_q : acc_q;

    op_d           = op_q;
    mcand_d        = mcand_q;
    acc_d          = acc_q;
    mplier_d       = mplier_q;
    count_d        = count_q;
    neg_d          = neg_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d     = mul_op_e'(op);
          mcand_d  = {{XLEN{1'b0}}, rs1_abs};
          mplier_d = rs2_abs;
          acc_d    = '0;
          count_d  = '0;
          neg_d    = rs1_neg ^ rs2_neg;
        end
      end
      RUN: begin
        if (!flush) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
        end
      end
      FIX: begin
        if (!flush) begin
          result_d       = (op_q == MUL_OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          result_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= MUL_OP_MUL;
      mcand_q        <= '0;
      acc_q          <= '0;
      mplier_q       <= '0;
      count_q        <= '0;
      neg_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      op_q           <= op_d;
      mcand_q        <= mcand_d;
      acc_q          <= acc_d;
      mplier_q       <= mplier_d;
      count_q        <= count_d;
      neg_q          <= neg_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_unit_seq.sv
// Directed bench for mul_unit_seq: latency, product halves, flush, reset and back-to-back issue.
// Handshake: start is taken only when the unit is idle (busy=0); result_valid pulses one cycle with result.
module tb_mul_unit_seq;
  import riscv_m_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            flush = 1'b0;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcyc;

  mul_unit_seq #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge; cyc numbers the cycle now in progress
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request in cycle 0; returns in cycle 1 with start dropped
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
  endtask

  // Step until result_valid is seen or cyc reaches limit; vc=-1 if never seen
  task automatic wait_valid(output int vc, input int limit);
    vc = -1;
    while (cyc < limit) begin
      if (result_valid) begin
        vc = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int vc;
    issue(o, a, b);
    wait_valid(vc, 60);
    chk({tag, "_cycle"}, vc, 34);
    chk({tag, "_result"}, result, exp);
    step();
    chk({tag, "_pulse"}, {31'b0, result_valid}, 32'd0);
  endtask

  initial begin
    // Reset
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_valid", {31'b0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Latency and busy window on MUL 7*6
    issue(MUL_OP_MUL, 32'd7, 32'd6);
    while (cyc <= 33) begin
      chk($sformatf("busy_c%0d", cyc), {31'b0, busy}, 32'd1);
      chk($sformatf("novalid_c%0d", cyc), {31'b0, result_valid}, 32'd0);
      step();
    end
    chk("mul7x6_busy_c34", {31'b0, busy}, 32'd0);
    chk("mul7x6_valid_c34", {31'b0, result_valid}, 32'd1);
    chk("mul7x6_result", result, 32'h0000_002A);
    step();
    chk("mul7x6_pulse", {31'b0, result_valid}, 32'd0);
    chk("mul7x6_hold", result, 32'h0000_002A);

    // Product halves and signedness
    run_op("mul_neg3x5",     MUL_OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
    run_op("mulh_min_min",   MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu_m1_max",  MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_max_max",  MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_neg3x5",    MUL_OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
    run_op("mulh_pmax_pmax", MUL_OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
    run_op("mulhsu_min_x2",  MUL_OP_MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF);
    run_op("mulh_pos_neg",   MUL_OP_MULH,   32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_op("mulhu_2p16sq",   MUL_OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    run_op("mul_zero",       MUL_OP_MUL,    32'd0,         32'h1234_5678, 32'h0000_0000);
    run_op("mul_low_wrap",   MUL_OP_MUL,    32'h8000_0001, 32'd3,         32'h8000_0003);

    // Flush in cycle 10: idle in cycle 11, no valid, result kept
    issue(MUL_OP_MUL, 32'd3, 32'd3);
    while (cyc < 10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy_c11", {31'b0, busy}, 32'd0);
    wait_valid(vcyc, 50);
    chk("flush_no_valid", vcyc, -1);
    chk("flush_result_kept", result, 32'h8000_0003);

    // Flush wins over start in IDLE
    op = MUL_OP_MUL; rs1 = 32'd9; rs2 = 32'd9;
    start = 1'b1; flush = 1'b1; cyc = 0;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    wait_valid(vcyc, 45);
    chk("flush_start_no_valid", vcyc, -1);
    chk("flush_start_result", result, 32'h8000_0003);

    // start in cycle 5 while busy is ignored
    issue(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    while (cyc < 5) step();
    op = MUL_OP_MUL; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(vcyc, 60);
    chk("busy_start_cycle", vcyc, 34);
    chk("busy_start_result", result, 32'hFFFF_FFFE);
    step();
    wait_valid(vcyc, 100);
    chk("busy_start_single_valid", vcyc, -1);

    // Reset asserted in cycle 15 aborts immediately
    issue(MUL_OP_MUL, 32'd7, 32'd6);
    while (cyc < 15) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_valid", {31'b0, result_valid}, 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wait_valid(vcyc, 60);
    chk("midreset_no_valid", vcyc, -1);
    chk("midreset_busy_after", {31'b0, busy}, 32'd0);

    // Back-to-back: second start in the valid cycle 34, second valid in cycle 68
    issue(MUL_OP_MUL, 32'd7, 32'd6);
    wait_valid(vcyc, 60);
    chk("b2b_first_cycle", vcyc, 34);
    chk("b2b_first_result", result, 32'h0000_002A);
    op = MUL_OP_MULHU; rs1 = 32'h0001_0000; rs2 = 32'h0003_0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy_c35", {31'b0, busy}, 32'd1);
    while (cyc < 50) step();
    chk("b2b_result_held", result, 32'h0000_002A);
    wait_valid(vcyc, 90);
    chk("b2b_second_cycle", vcyc, 68);
    chk("b2b_second_result", result, 32'h0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
